// File: rtl/fpu_add_sequencer.sv
// fpu_add_sequencer: control FSM stepping the FPU add datapath through align/add/norm/expupd/denorm/round
// Ports: start_valid/start_ready accept an operation; op_special bypasses straight to the result;
// max_exponent_z/underflow_flag/excessive_shift_left are sampled in EXPUPD; *_en are one-cycle stage enables;
// shift_en/shift_amt drive one denormalization step; result_valid/result_ready hand off the result together
// with force_inf and the sticky overflow_o/underflow_o status; busy is high whenever not idle.
module fpu_add_sequencer #(
    parameter int MAX_STEP  = 8,
    parameter int SHIFT_SAT = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic       op_special,
    input  logic       max_exponent_z,
    input  logic       min_exponent_z,
    input  logic       underflow_flag,
    input  logic [9:0] excessive_shift_left,
    output logic       align_en,
    output logic       add_en,
    output logic       norm_en,
    output logic       expupd_en,
    output logic       round_en,
    output logic       shift_en,
    output logic [3:0] shift_amt,
    output logic       force_inf,
    output logic       result_valid,
    input  logic       result_ready,
    output logic       overflow_o,
    output logic       underflow_o,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, EXPUPD, DENORM, ROUND, DONE} state_t;
    localparam logic [4:0] STEP  = 5'(MAX_STEP);
    localparam logic [4:0] SAT   = 5'(SHIFT_SAT);
    localparam logic [9:0] SAT10 = 10'(SHIFT_SAT);
    state_t state, state_n;
    logic [4:0] rem, rem_n, step;
    logic ovf_n, unf_n, inf_n;
    // min_exponent_z alone is a legal zero/subnormal result and never changes control flow
    logic unused;
    assign unused = min_exponent_z;
    assign start_ready = state == IDLE;
    assign step = rem > STEP ? STEP : rem;
    always_comb begin
        state_n = state;
        rem_n   = rem;
        ovf_n   = overflow_o;
        unf_n   = underflow_o;
        inf_n   = force_inf;
        case (state)
            IDLE:
                if (start_valid) begin
                    ovf_n   = 1'b0;
                    unf_n   = 1'b0;
                    inf_n   = 1'b0;
                    state_n = op_special ? DONE : ALIGN;
                end
            ALIGN:  state_n = ADD;
            ADD:    state_n = NORM;
            NORM:   state_n = EXPUPD;
            EXPUPD:
                if (max_exponent_z) begin
                    ovf_n   = 1'b1;
                    inf_n   = 1'b1;
                    state_n = DONE;
                end else if (underflow_flag) begin
                    // saturate before loading so the 5-bit counter can never wrap
                    unf_n   = 1'b1;
                    rem_n   = excessive_shift_left > SAT10 ? SAT : excessive_shift_left[4:0];
                    state_n = rem_n != 5'd0 ? DENORM : ROUND;
                end else begin
                    state_n = ROUND;
                end
            DENORM: begin
                rem_n   = rem - step;
                state_n = rem_n == 5'd0 ? ROUND : DENORM;
            end
            ROUND:  state_n = DONE;
            DONE:   state_n = result_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end
    // outputs are registered from the next state so each enable lines up with its state cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rem          <= 5'd0;
            overflow_o   <= 1'b0;
            underflow_o  <= 1'b0;
            force_inf    <= 1'b0;
            align_en     <= 1'b0;
            add_en       <= 1'b0;
            norm_en      <= 1'b0;
            expupd_en    <= 1'b0;
            round_en     <= 1'b0;
            shift_en     <= 1'b0;
            shift_amt    <= 4'd0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            rem          <= rem_n;
            overflow_o   <= ovf_n;
            underflow_o  <= unf_n;
            force_inf    <= inf_n;
            align_en     <= state_n == ALIGN;
            add_en       <= state_n == ADD;
            norm_en      <= state_n == NORM;
            expupd_en    <= state_n == EXPUPD;
            round_en     <= state_n == ROUND;
            shift_en     <= state_n == DENORM;
            shift_amt    <= state_n == DENORM ? (rem_n > STEP ? 4'(MAX_STEP) : rem_n[3:0]) : 4'd0;
            result_valid <= state_n == DONE;
            busy         <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_fpu_add_sequencer.sv
// tb_fpu_add_sequencer: directed self-checking bench for fpu_add_sequencer
module tb_fpu_add_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_valid = 1'b0;
    logic       op_special = 1'b0;
    logic       max_exponent_z = 1'b0;
    logic       min_exponent_z = 1'b0;
    logic       underflow_flag = 1'b0;
    logic [9:0] excessive_shift_left = 10'd0;
    logic       result_ready = 1'b1;
    logic       start_ready, align_en, add_en, norm_en, expupd_en, round_en, shift_en;
    logic [3:0] shift_amt;
    logic       force_inf, result_valid, overflow_o, underflow_o, busy;
    int checks = 0;
    int errors = 0;
    wire [6:0] en = {align_en, add_en, norm_en, expupd_en, round_en, shift_en, result_valid};
    wire [2:0] st = {overflow_o, underflow_o, force_inf};

    fpu_add_sequencer dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .op_special(op_special), .max_exponent_z(max_exponent_z), .min_exponent_z(min_exponent_z),
        .underflow_flag(underflow_flag), .excessive_shift_left(excessive_shift_left),
        .align_en(align_en), .add_en(add_en), .norm_en(norm_en), .expupd_en(expupd_en),
        .round_en(round_en), .shift_en(shift_en), .shift_amt(shift_amt), .force_inf(force_inf),
        .result_valid(result_valid), .result_ready(result_ready), .overflow_o(overflow_o),
        .underflow_o(underflow_o), .busy(busy)
    );

    always #5 clk = ~clk;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task test_reset;
        rst = 1'b1;
        tick;
        tick;
        checks++; if (en !== 7'd0) begin errors++; $display("FAIL reset_en got %b want 0000000", en); end
        checks++; if (shift_amt !== 4'd0) begin errors++; $display("FAIL reset_shift_amt got %0d want 0", shift_amt); end
        checks++; if (st !== 3'b000) begin errors++; $display("FAIL reset_status got %b want 000", st); end
        checks++; if ({start_ready, busy} !== 2'b10) begin errors++; $display("FAIL reset_ready_busy got %b want 10", {start_ready, busy}); end
        rst = 1'b0;
    endtask

    task test_normal(input string tag);
        logic [6:0] exp_en [6];
        exp_en = '{7'b1000000, 7'b0100000, 7'b0010000, 7'b0001000, 7'b0000100, 7'b0000001};
        start_valid = 1'b1;
        tick;
        start_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++; if (en !== exp_en[i]) begin errors++; $display("FAIL %s_en T+%0d got %b want %b", tag, i + 1, en, exp_en[i]); end
            if (i < 5) tick;
        end
        checks++; if (st !== 3'b000) begin errors++; $display("FAIL %s_status got %b want 000", tag, st); end
        checks++; if ({start_ready, busy} !== 2'b01) begin errors++; $display("FAIL %s_done_ready_busy got %b want 01", tag, {start_ready, busy}); end
        tick;
        checks++; if ({en, start_ready, busy} !== 9'b0000000_10) begin errors++; $display("FAIL %s_idle got %b want 000000010", tag, {en, start_ready, busy}); end
    endtask

    task test_special;
        op_special = 1'b1;
        start_valid = 1'b1;
        tick;
        start_valid = 1'b0;
        op_special = 1'b0;
        checks++; if (en !== 7'b0000001) begin errors++; $display("FAIL special_en T+1 got %b want 0000001", en); end
        checks++; if (st !== 3'b000) begin errors++; $display("FAIL special_status got %b want 000", st); end
        tick;
        checks++; if ({en, start_ready} !== 8'b0000000_1) begin errors++; $display("FAIL special_idle got %b want 00000001", {en, start_ready}); end
    endtask

    task test_overflow;
        logic [6:0] exp_en [5];
        exp_en = '{7'b1000000, 7'b0100000, 7'b0010000, 7'b0001000, 7'b0000001};
        max_exponent_z = 1'b1;
        underflow_flag = 1'b1;
        excessive_shift_left = 10'd20;
        start_valid = 1'b1;
        tick;
        start_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (en !== exp_en[i]) begin errors++; $display("FAIL overflow_en T+%0d got %b want %b", i + 1, en, exp_en[i]); end
            if (i < 4) tick;
        end
        checks++; if (st !== 3'b101) begin errors++; $display("FAIL overflow_status got %b want 101", st); end
        max_exponent_z = 1'b0;
        underflow_flag = 1'b0;
        excessive_shift_left = 10'd0;
        tick;
        checks++; if ({en, start_ready} !== 8'b0000000_1) begin errors++; $display("FAIL overflow_idle got %b want 00000001", {en, start_ready}); end
    endtask

    task test_denorm(input logic [9:0] s, input int n, input logic [3:0] a0, input logic [3:0] a1,
                     input logic [3:0] a2, input logic [3:0] a3);
        logic [6:0] exp_en [4];
        logic [3:0] amts [4];
        exp_en = '{7'b1000000, 7'b0100000, 7'b0010000, 7'b0001000};
        amts = '{a0, a1, a2, a3};
        underflow_flag = 1'b1;
        excessive_shift_left = s;
        start_valid = 1'b1;
        tick;
        start_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (en !== exp_en[i]) begin errors++; $display("FAIL denorm%0d_en T+%0d got %b want %b", s, i + 1, en, exp_en[i]); end
            tick;
        end
        for (int k = 0; k < n; k++) begin
            checks++; if ({en, shift_amt} !== {7'b0000010, amts[k]}) begin errors++; $display("FAIL denorm%0d_step%0d got en=%b amt=%0d want en=0000010 amt=%0d", s, k, en, shift_amt, amts[k]); end
            tick;
        end
        checks++; if ({en, shift_amt} !== {7'b0000100, 4'd0}) begin errors++; $display("FAIL denorm%0d_round got en=%b amt=%0d want en=0000100 amt=0", s, en, shift_amt); end
        tick;
        checks++; if ({en, st} !== {7'b0000001, 3'b010}) begin errors++; $display("FAIL denorm%0d_done got en=%b st=%b want en=0000001 st=010", s, en, st); end
        underflow_flag = 1'b0;
        excessive_shift_left = 10'd0;
        tick;
        checks++; if ({en, start_ready} !== 8'b0000000_1) begin errors++; $display("FAIL denorm%0d_idle got %b want 00000001", s, {en, start_ready}); end
    endtask

    task test_backpressure;
        underflow_flag = 1'b1;
        result_ready = 1'b0;
        start_valid = 1'b1;
        tick;
        start_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        for (int i = 0; i < 5; i++) begin
            start_valid = 1'b1;
            checks++; if ({en, st, start_ready, busy} !== {7'b0000001, 3'b010, 2'b01}) begin errors++; $display("FAIL hold%0d got en=%b st=%b rdy=%b busy=%b want en=0000001 st=010 rdy=0 busy=1", i, en, st, start_ready, busy); end
            tick;
        end
        underflow_flag = 1'b0;
        result_ready = 1'b1;
        tick;
        checks++; if ({en, start_ready, busy} !== 9'b0000000_10) begin errors++; $display("FAIL hold_release got %b want 000000010", {en, start_ready, busy}); end
        start_valid = 1'b0;
        tick;
        checks++; if ({en, start_ready} !== 8'b0000000_1) begin errors++; $display("FAIL hold_no_accept got %b want 00000001", {en, start_ready}); end
    endtask

    task test_reset_mid;
        underflow_flag = 1'b1;
        excessive_shift_left = 10'd20;
        start_valid = 1'b1;
        tick;
        start_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        checks++; if ({en, shift_amt} !== {7'b0000010, 4'd8}) begin errors++; $display("FAIL rstmid_pre got en=%b amt=%0d want en=0000010 amt=8", en, shift_amt); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({en, shift_amt, st, start_ready, busy} !== {7'd0, 4'd0, 3'd0, 2'b10}) begin errors++; $display("FAIL rstmid_async got en=%b amt=%0d st=%b rdy=%b busy=%b want all reset", en, shift_amt, st, start_ready, busy); end
        underflow_flag = 1'b0;
        excessive_shift_left = 10'd0;
        tick;
        checks++; if ({en, busy} !== 8'd0) begin errors++; $display("FAIL rstmid_hold got %b want 00000000", {en, busy}); end
        rst = 1'b0;
        tick;
        test_normal("after_rst");
    endtask

    initial begin
        test_reset;
        test_normal("normal");
        min_exponent_z = 1'b1;
        test_normal("minexp");
        min_exponent_z = 1'b0;
        test_special;
        test_overflow;
        test_denorm(10'd0, 0, 4'd0, 4'd0, 4'd0, 4'd0);
        test_denorm(10'd8, 1, 4'd8, 4'd0, 4'd0, 4'd0);
        test_denorm(10'd20, 3, 4'd8, 4'd8, 4'd4, 4'd0);
        test_denorm(10'd300, 4, 4'd8, 4'd8, 4'd8, 4'd3);
        test_denorm(10'd1023, 4, 4'd8, 4'd8, 4'd8, 4'd3);
        test_normal("clear_after_underflow");
        test_backpressure;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
